class_binarize_sequencer: RTL

Sequences binarization of the non-binary class hypervector memory. On a `start` command it walks every enabled class and every chunk of `DIMS_PER_CC` dimensions. For each chunk it does four things: reads the chunk from the non-binary class memory, drives the combinational class thresholder, captures the thresholded chunk, and writes it into the binary class memory. It sits between the training controller (command side), the non-binary class memory read port, the thresholder, and the binary class memory write port.

---
 rtl/class_binarize_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/class_binarize_sequencer.sv
// ============================================================================
// class_binarize_sequencer
// Walks enabled classes and their chunks: read non-binary memory, threshold,
// capture, and write the result into binary class memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module class_binarize_sequencer #(
    parameter int NUM_CLASSES      = 10,
    parameter int CHUNKS_PER_CLASS = 16,
    parameter int DIMS_PER_CC      = 64,
    parameter int CLS_W            = $clog2(NUM_CLASSES),
    parameter int CHK_W            = $clog2(CHUNKS_PER_CLASS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_CLASSES-1:0]   class_mask,
    output logic                     busy,
    output logic                     done,
    output logic [CLS_W+CHK_W:0]     wr_count,
    output logic                     nb_rd_en,
    output logic [CLS_W-1:0]         nb_rd_class,
    output logic [CHK_W-1:0]         nb_rd_chunk,
    output logic                     thr_en,
    output logic                     binarizing_class_hvs,
    input  logic [DIMS_PER_CC-1:0]   thr_hv,
    output logic                     b_wr_en,
    output logic [CLS_W-1:0]         b_wr_class,
    output logic [CHK_W-1:0]         b_wr_chunk,
    output logic [DIMS_PER_CC-1:0]   b_wr_data,
    input  logic                     b_wr_ready
);

    localparam int CNT_W = CLS_W + CHK_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state_q;
    logic [NUM_CLASSES-1:0] mask_q;
    logic [CLS_W-1:0]       class_q;
    logic [CHK_W-1:0]       chunk_q;
    logic [CNT_W-1:0]       wr_count_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   nb_rd_en_q;
    logic                   thr_en_q;
    logic                   b_wr_en_q;
    logic [CLS_W-1:0]       b_wr_class_q;
    logic [CHK_W-1:0]       b_wr_chunk_q;
    logic [DIMS_PER_CC-1:0] b_wr_data_q;

    logic [CLS_W-1:0]       first_cls_d;
    logic [CLS_W-1:0]       next_cls_d;
    logic                   has_next_d;
    logic                   last_chunk_d;

    // Priority searches let masked-off classes be skipped without extra cycles.
    always_comb begin
        first_cls_d = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (class_mask[i]) begin
                first_cls_d = CLS_W'(i);
            end
        end
        next_cls_d = '0;
        has_next_d = 1'b0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (mask_q[i] && (CLS_W'(i) > class_q)) begin
                next_cls_d = CLS_W'(i);
                has_next_d = 1'b1;
            end
        end
        last_chunk_d = (chunk_q == CHK_W'(CHUNKS_PER_CLASS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            class_q      <= '0;
            chunk_q      <= '0;
            wr_count_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            nb_rd_en_q   <= 1'b0;
            thr_en_q     <= 1'b0;
            b_wr_en_q    <= 1'b0;
            b_wr_class_q <= '0;
            b_wr_chunk_q <= '0;
            b_wr_data_q  <= '0;
        end else begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nb_rd_en_q <= 1'b0;
            thr_en_q   <= 1'b0;
            b_wr_en_q  <= 1'b0;

            // Abort wins over a same-cycle handshake, so wr_count is left alone.
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            mask_q     <= class_mask;
                            wr_count_q <= '0;
                            if (|class_mask) begin
                                state_q    <= S_RD;
                                class_q    <= first_cls_d;
                                chunk_q    <= '0;
                                busy_q     <= 1'b1;
                                nb_rd_en_q <= 1'b1;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_RD: begin
                        state_q  <= S_CAP;
                        busy_q   <= 1'b1;
                        thr_en_q <= 1'b1;
                    end
                    S_CAP: begin
                        state_q      <= S_WR;
                        busy_q       <= 1'b1;
                        b_wr_en_q    <= 1'b1;
                        b_wr_data_q  <= thr_hv;
                        b_wr_class_q <= class_q;
                        b_wr_chunk_q <= chunk_q;
                    end
                    S_WR: begin
                        if (b_wr_ready) begin
                            wr_count_q <= wr_count_q + CNT_W'(1);
                            if (!last_chunk_d) begin
                                state_q    <= S_RD;
                                chunk_q    <= chunk_q + CHK_W'(1);
                                busy_q     <= 1'b1;
                                nb_rd_en_q <= 1'b1;
                            end else if (has_next_d) begin
                                state_q    <= S_RD;
                                chunk_q    <= '0;
                                class_q    <= next_cls_d;
                                busy_q     <= 1'b1;
                                nb_rd_en_q <= 1'b1;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            busy_q    <= 1'b1;
                            b_wr_en_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign wr_count             = wr_count_q;
    assign nb_rd_en             = nb_rd_en_q;
    assign nb_rd_class          = class_q;
    assign nb_rd_chunk          = chunk_q;
    assign thr_en               = thr_en_q;
    assign binarizing_class_hvs = thr_en_q;
    assign b_wr_en              = b_wr_en_q;
    assign b_wr_class           = b_wr_class_q;
    assign b_wr_chunk           = b_wr_chunk_q;
    assign b_wr_data            = b_wr_data_q;

endmodule

`default_nettype wire
